instruction_decoder: RTL and testbench
======================================

# instruction_decoder

Execution stage directly downstream of the instruction fetch state machine. Accepts one 16-bit instruction word (opcode byte, operand byte) per start/ready handshake, decodes it, and executes it against an 8-bit accumulator with zero/carry flags. Signals readiness for the next word via `ready`. Handles multi-cycle shifts, halt, and illegal opcodes.

## Interface
- `BYTE`, 8, width of accumulator, opcode, and operand
- `WIDTH_IN`, 16, instruction width; `[15:8]` opcode, `[7:0]` operand
- `clk`  in  1  single clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `start`  in  1  instruction valid; sampled only when `ready`=1
- `instruction`  in  16  instruction word; captured on accepted `start`
- `ready`  out  1  high when idle and able to accept `start`
- `acc`  out  8  accumulator
- `zero`  out  1  zero flag
- `carry`  out  1  carry/borrow flag
- `halted`  out  1  HALT executed; sticky until reset
- `illegal`  out  1  undefined opcode seen; sticky until reset
- `instr_count`  out  8  count of retired instructions, wraps 255→0

## Operation
- Reset values: `ready`=1, `acc`=0, `zero`=0, `carry`=0, `halted`=0, `illegal`=0, `instr_count`=0, state IDLE.
- States: IDLE, DECODE, EXECUTE, SHIFT, HALT.
- IDLE: `ready`=1. On `start`=1, latch `instruction` into internal opcode/operand registers and go to DECODE. `ready` drops on the following cycle.
- DECODE: classify opcode; go to SHIFT if SHL with operand[2:0]≠0, HALT if 0xFF, else EXECUTE.
- EXECUTE: apply operation; increment `instr_count`; return to IDLE.
- Opcodes:
  - 0x00 NOP: no flag change.
  - 0x01 LDI: acc=op.
  - 0x02 ADD: {carry,acc}=acc+op.
  - 0x03 SUB: acc=acc−op; carry=1 iff acc<op (borrow).
  - 0x04 AND, 0x05 OR, 0x06 XOR: bitwise; carry unchanged.
  - 0x07 SHL: shift acc left by op[2:0]; op[7:3] ignored.
  - 0xFF HALT.
- `zero` is updated on LDI/ADD/SUB/AND/OR/XOR/SHL as (result==0).
- SHL: count = op[2:0]. If count=0, executes as one EXECUTE cycle with acc, carry, and zero unchanged except zero recomputed. Otherwise, SHIFT does one bit per cycle: carry←acc[7], acc←acc<<1. It loops count cycles, then updates `zero`, retires, and returns to IDLE.
- HALT: set `halted`, retire (count increments), stay in HALT with `ready`=0 until reset. `start` is ignored.
- Illegal opcode (0x08–0xFE): set `illegal`; acc and flags unchanged; retire; return to IDLE.
- All arithmetic is 8-bit modulo 256; `instr_count` wraps silently.

## Timing
- Edge N samples `start`=1 with `ready`=1. Then: N+1 DECODE (`ready`=0), N+2 EXECUTE, N+3 IDLE (`ready`=1). Results are visible from N+3.
- SHL count k≥1: N+1 DECODE, N+2..N+1+k SHIFT, IDLE at N+2+k.
- Minimum spacing between accepted instructions: 3 cycles.
- `start` while `ready`=0 is ignored and never queued.
- `instruction` needs to be valid only on the accepting edge.
- `reset`=1 on any edge overrides everything, including mid-SHIFT and HALT. `reset` together with `start` means the instruction is not accepted.

## Test plan
- Reset then LDI 0x05 (0x0105): `ready` low 2 cycles then high; acc=0x05, zero=0, instr_count=1.
- acc=0xF0, ADD 0x20 (0x0220): acc=0x10, carry=1, zero=0. Then SUB 0x10 (0x0310): acc=0x00, carry=0, zero=1.
- acc=0x81, SHL 3 (0x0703): `ready` low 4 cycles; acc=0x08, carry=0. Repeat with acc=0xC0, SHL 1: acc=0x80, carry=1.
- Opcode 0x42 with acc=0x33: illegal=1, acc=0x33, count increments, `ready` returns; next LDI executes normally.
- HALT (0xFF00): halted=1, `ready` stays 0 for 10+ cycles despite `start` pulses. Then reset: all outputs return to reset values.
- Pulse `start` during DECODE: ignored. Assert `reset` mid-SHIFT: next cycle `ready`=1, acc=0. Run 256 NOPs: instr_count wraps to 0.

Source files
------------

// File: rtl/instruction_decoder.sv
// Execution stage behind instruction fetch: latches one opcode/operand word per
// start/ready handshake and runs it against an 8-bit accumulator with zero/carry flags.
module instruction_decoder #(
    parameter int BYTE     = 8,
    parameter int WIDTH_IN = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WIDTH_IN-1:0] instruction,
    output logic                ready,
    output logic [BYTE-1:0]     acc,
    output logic                zero,
    output logic                carry,
    output logic                halted,
    output logic                illegal,
    output logic [7:0]          instr_count
);

    localparam logic [BYTE-1:0] OP_NOP  = 8'h00;
    localparam logic [BYTE-1:0] OP_LDI  = 8'h01;
    localparam logic [BYTE-1:0] OP_ADD  = 8'h02;
    localparam logic [BYTE-1:0] OP_SUB  = 8'h03;
    localparam logic [BYTE-1:0] OP_AND  = 8'h04;
    localparam logic [BYTE-1:0] OP_OR   = 8'h05;
    localparam logic [BYTE-1:0] OP_XOR  = 8'h06;
    localparam logic [BYTE-1:0] OP_SHL  = 8'h07;
    localparam logic [BYTE-1:0] OP_HALT = 8'hFF;

    typedef enum logic [2:0] {IDLE, DECODE, EXECUTE, SHIFT, HALT} state_t;

    state_t          state, state_nxt;
    logic [BYTE-1:0] opcode, operand;
    logic [2:0]      shift_cnt;
    logic [BYTE:0]   sum, diff;

    assign ready = (state == IDLE);
    assign sum   = {1'b0, acc} + {1'b0, operand};
    // diff[BYTE] is the borrow out, i.e. acc < operand
    assign diff  = {1'b0, acc} - {1'b0, operand};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = DECODE;
            DECODE: begin
                if (opcode == OP_SHL && operand[2:0] != 3'd0) state_nxt = SHIFT;
                else if (opcode == OP_HALT)                    state_nxt = HALT;
                else                                           state_nxt = EXECUTE;
            end
            EXECUTE: state_nxt = IDLE;
            SHIFT:   if (shift_cnt == 3'd1) state_nxt = IDLE;
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            opcode      <= '0;
            operand     <= '0;
            shift_cnt   <= '0;
            acc         <= '0;
            zero        <= 1'b0;
            carry       <= 1'b0;
            halted      <= 1'b0;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        opcode  <= instruction[WIDTH_IN-1:BYTE];
                        operand <= instruction[BYTE-1:0];
                    end
                end
                DECODE: begin
                    shift_cnt <= operand[2:0];
                    if (opcode == OP_HALT) begin
                        halted      <= 1'b1;
                        instr_count <= instr_count + 8'd1;
                    end
                end
                EXECUTE: begin
                    instr_count <= instr_count + 8'd1;
                    case (opcode)
                        OP_NOP: ;
                        OP_LDI: begin acc <= operand; zero <= (operand == '0); end
                        OP_ADD: begin
                            acc   <= sum[BYTE-1:0];
                            carry <= sum[BYTE];
                            zero  <= (sum[BYTE-1:0] == '0);
                        end
                        OP_SUB: begin
                            acc   <= diff[BYTE-1:0];
                            carry <= diff[BYTE];
                            zero  <= (diff[BYTE-1:0] == '0);
                        end
                        OP_AND: begin acc <= acc & operand; zero <= ((acc & operand) == '0); end
                        OP_OR:  begin acc <= acc | operand; zero <= ((acc | operand) == '0); end
                        OP_XOR: begin acc <= acc ^ operand; zero <= ((acc ^ operand) == '0); end
                        // only a zero-count shift lands here; acc and carry stay put
                        OP_SHL: zero <= (acc == '0);
                        default: illegal <= 1'b1;
                    endcase
                end
                SHIFT: begin
                    carry     <= acc[BYTE-1];
                    acc       <= {acc[BYTE-2:0], 1'b0};
                    shift_cnt <= shift_cnt - 3'd1;
                    if (shift_cnt == 3'd1) begin
                        zero        <= (acc[BYTE-2:0] == '0);
                        instr_count <= instr_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_decoder.sv
// Scoreboarded random + directed bench for instruction_decoder; expectations come
// from an arithmetic reference model, checked when ready rises after each instruction.
module tb_instruction_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] instruction = '0;
    logic        ready;
    logic [7:0]  acc;
    logic        zero, carry, halted, illegal;
    logic [7:0]  instr_count;

    instruction_decoder dut (
        .clk(clk), .reset(reset), .start(start), .instruction(instruction),
        .ready(ready), .acc(acc), .zero(zero), .carry(carry),
        .halted(halted), .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ins;
        logic [7:0]  acc;
        logic        z, c, ill;
        logic [7:0]  cnt;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   flush = 1'b1;

    // reference model state
    int m_acc, m_cnt;
    bit m_z, m_c, m_ill, m_hlt;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, a, e);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_cnt = 0; m_z = 0; m_c = 0; m_ill = 0; m_hlt = 0;
    endtask

    // Returns the number of cycles ready should stay low.
    task automatic model_exec(input logic [15:0] ins, output int lat);
        int op, v, k;
        op  = ins[15:8];
        v   = ins[7:0];
        lat = 2;
        case (op)
            0: ;
            1: begin m_acc = v; m_z = (m_acc == 0); end
            2: begin m_c = (m_acc + v) > 255; m_acc = (m_acc + v) % 256; m_z = (m_acc == 0); end
            3: begin m_c = m_acc < v; m_acc = (m_acc - v + 256) % 256; m_z = (m_acc == 0); end
            4: begin m_acc = m_acc & v; m_z = (m_acc == 0); end
            5: begin m_acc = m_acc | v; m_z = (m_acc == 0); end
            6: begin m_acc = m_acc ^ v; m_z = (m_acc == 0); end
            7: begin
                k = v % 8;
                for (int i = 0; i < k; i++) begin
                    m_c   = (m_acc >= 128);
                    m_acc = (m_acc * 2) % 256;
                end
                m_z = (m_acc == 0);
                lat = (k == 0) ? 2 : 1 + k;
            end
            255: m_hlt = 1;
            default: m_ill = 1;
        endcase
        m_cnt = (m_cnt + 1) % 256;
    endtask

    // Monitor: every rising ready retires the oldest expected instruction.
    int low_cnt = 0;
    bit prev_ready = 1'b1;
    always @(negedge clk) begin
        exp_t e;
        if (reset || flush) begin
            low_cnt    = 0;
            prev_ready = 1'b1;
        end else if (!ready) begin
            low_cnt++;
            prev_ready = 1'b0;
        end else begin
            if (!prev_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_retire", 32'(low_cnt), 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("acc[%h]", e.ins), 32'(acc), 32'(e.acc));
                    chk($sformatf("zero[%h]", e.ins), 32'(zero), 32'(e.z));
                    chk($sformatf("carry[%h]", e.ins), 32'(carry), 32'(e.c));
                    chk($sformatf("illegal[%h]", e.ins), 32'(illegal), 32'(e.ill));
                    chk($sformatf("count[%h]", e.ins), 32'(instr_count), 32'(e.cnt));
                    chk($sformatf("busy_cycles[%h]", e.ins), 32'(low_cnt), 32'(e.lat));
                end
            end
            low_cnt    = 0;
            prev_ready = 1'b1;
        end
    end

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk({nm, "_timeout"}, 32'(ready), 32'd1);
    endtask

    // Issue at a negedge with ready high; optionally pulse a stray start during DECODE.
    task automatic issue(input logic [15:0] ins, input bit stray, input bit wait_done);
        exp_t e;
        int   lat;
        wait_ready("issue");
        start       = 1'b1;
        instruction = ins;
        model_exec(ins, lat);
        if (ins[15:8] != 8'hFF) begin
            e.ins = ins; e.acc = 8'(m_acc); e.z = m_z; e.c = m_c;
            e.ill = m_ill; e.cnt = 8'(m_cnt); e.lat = lat;
            q.push_back(e);
        end
        @(negedge clk);
        if (stray) begin
            instruction = 16'h01AA;
            @(negedge clk);
        end
        start       = 1'b0;
        instruction = $urandom;
        if (wait_done) wait_ready("done");
    endtask

    task automatic do_reset();
        flush = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        model_reset();
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_ready"},   32'(ready), 32'd1);
        chk({nm, "_acc"},     32'(acc), 32'd0);
        chk({nm, "_zero"},    32'(zero), 32'd0);
        chk({nm, "_carry"},   32'(carry), 32'd0);
        chk({nm, "_halted"},  32'(halted), 32'd0);
        chk({nm, "_illegal"}, 32'(illegal), 32'd0);
        chk({nm, "_count"},   32'(instr_count), 32'd0);
    endtask

    logic [15:0] directed [] = '{
        16'h0105, 16'h01F0, 16'h0220, 16'h0310, 16'h0181, 16'h0703,
        16'h01C0, 16'h0701, 16'h0133, 16'h4233, 16'h0107, 16'h07F8,
        16'h0100, 16'h0700, 16'h0301, 16'h04F0, 16'h0555, 16'h06FF,
        16'h0180, 16'h0707, 16'hFE00, 16'h0000
    };

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);
        flush = 1'b0;

        foreach (directed[i]) issue(directed[i], 1'b0, 1'b1);

        // stray start while in DECODE must be ignored
        issue(16'h0111, 1'b1, 1'b1);
        issue(16'h0201, 1'b1, 1'b1);

        for (int i = 0; i < 80; i++) begin
            logic [15:0] ins;
            ins[7:0]  = 8'($urandom);
            ins[15:8] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(8, 254))
                                                     : 8'($urandom_range(0, 7));
            issue(ins, 1'b0, 1'b0);
        end
        wait_ready("rand_drain");

        // HALT: ready must stay low and start is ignored
        issue(16'hFF00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_count", 32'(instr_count), 32'(m_cnt));
        for (int i = 0; i < 12; i++) begin
            start = i[0];
            instruction = 16'h0177;
            @(negedge clk);
            chk("halt_ready_low", 32'(ready), 32'd0);
        end
        start = 1'b0;
        chk("halt_acc_kept", 32'(acc), 32'(m_acc));
        do_reset();
        chk_reset_vals("post_halt");
        flush = 1'b0;

        // reset with start asserted: not accepted
        flush = 1'b1;
        reset = 1'b1; start = 1'b1; instruction = 16'h0155;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("reset_start_ready", 32'(ready), 32'd1);
        chk("reset_start_acc", 32'(acc), 32'd0);
        flush = 1'b0;

        // reset mid-SHIFT
        issue(16'h01FF, 1'b0, 1'b1);
        issue(16'h0707, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        do_reset();
        chk("midshift_ready", 32'(ready), 32'd1);
        chk("midshift_acc", 32'(acc), 32'd0);
        chk("midshift_count", 32'(instr_count), 32'd0);
        flush = 1'b0;

        // 256 NOPs: count wraps back to 0
        for (int i = 0; i < 256; i++) issue(16'h0000, 1'b0, 1'b0);
        wait_ready("nop_drain");
        @(negedge clk);
        chk("nop_wrap_count", 32'(instr_count), 32'd0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
